// File: rtl/rv_decode_issue_pkg.sv
// Shared types for the RV32I decode/issue stage: operand and register-port
// types, operation classes, opcode constants and the issue packet layout.
package rv_decode_issue_pkg;

  typedef logic [31:0] OperandType;

  typedef struct packed {
    logic       RegEnable;
    logic [4:0] RegAddr;
  } RegCtrlPortType;

  typedef struct packed {
    OperandType PhyRegReadData;
    logic       isRegAvailable;
  } RegReadPortType;

  typedef enum logic [3:0] {
    OC_LUI,
    OC_AUIPC,
    OC_JAL,
    OC_JALR,
    OC_BRANCH,
    OC_LOAD,
    OC_STORE,
    OC_OPIMM,
    OC_OP,
    OC_ILLEGAL
  } OpClassType;

  // Full 7-bit major opcodes; bits [1:0] are 2'b11 for all of them, so any
  // compressed or reserved encoding falls through to illegal.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    OperandType     PC;
    OpClassType     OpClass;
    logic [2:0]     Funct3;
    logic           Funct7b5;
    OperandType     Src1Data;
    OperandType     Src2Data;
    OperandType     Imm;
    RegCtrlPortType RdCtrl;
    logic           Illegal;
  } IssuePacketType;

endpackage

// File: rtl/rv_decode_issue_imm.sv
// Combinational RV32I decoder: operation class, source/destination register
// controls and the sign-extended immediate of one instruction word.
module rv_decode_imm
  import rv_decode_issue_pkg::*;
(
  input  logic [31:0]    instr_i,
  output OpClassType     op_class_o,
  output RegCtrlPortType rs1_ctrl_o,
  output RegCtrlPortType rs2_ctrl_o,
  output RegCtrlPortType rd_ctrl_o,
  output OperandType     imm_o,
  output logic           illegal_o
);

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       use_rs1;
  logic       use_rs2;
  logic       writes_rd;
  OperandType imm_i_fmt;
  OperandType imm_s_fmt;
  OperandType imm_b_fmt;
  OperandType imm_u_fmt;
  OperandType imm_j_fmt;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];

  assign imm_i_fmt = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_fmt = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_fmt = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u_fmt = {instr_i[31:12], 12'b0};
  assign imm_j_fmt = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};

  // Classify the opcode and select register usage and immediate format.
  always_comb begin
    op_class_o = OC_ILLEGAL;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    writes_rd  = 1'b0;
    imm_o      = '0;
    case (opcode)
      OPC_LUI: begin
        op_class_o = OC_LUI;
        writes_rd  = 1'b1;
        imm_o      = imm_u_fmt;
      end
      OPC_AUIPC: begin
        op_class_o = OC_AUIPC;
        writes_rd  = 1'b1;
        imm_o      = imm_u_fmt;
      end
      OPC_JAL: begin
        op_class_o = OC_JAL;
        writes_rd  = 1'b1;
        imm_o      = imm_j_fmt;
      end
      OPC_JALR: begin
        op_class_o = OC_JALR;
        use_rs1    = 1'b1;
        writes_rd  = 1'b1;
        imm_o      = imm_i_fmt;
      end
      OPC_BRANCH: begin
        op_class_o = OC_BRANCH;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        imm_o      = imm_b_fmt;
      end
      OPC_LOAD: begin
        op_class_o = OC_LOAD;
        use_rs1    = 1'b1;
        writes_rd  = 1'b1;
        imm_o      = imm_i_fmt;
      end
      OPC_STORE: begin
        op_class_o = OC_STORE;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        imm_o      = imm_s_fmt;
      end
      OPC_OPIMM: begin
        op_class_o = OC_OPIMM;
        use_rs1    = 1'b1;
        writes_rd  = 1'b1;
        imm_o      = imm_i_fmt;
      end
      OPC_OP: begin
        op_class_o = OC_OP;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        writes_rd  = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_o  = (op_class_o == OC_ILLEGAL);
  // Unused read ports present a zero address so the register file sees no
  // spurious activity; x0 is never reported as a write target.
  assign rs1_ctrl_o = '{RegEnable: use_rs1, RegAddr: (use_rs1 ? rs1 : 5'd0)};
  assign rs2_ctrl_o = '{RegEnable: use_rs2, RegAddr: (use_rs2 ? rs2 : 5'd0)};
  assign rd_ctrl_o  = '{RegEnable: (writes_rd && (rd != 5'd0)), RegAddr: rd};

endmodule

// File: rtl/rv_decode_issue.sv
// Decode/issue stage: holds one fetched instruction (IR), decodes it, waits
// for both source operands and moves the result into the issue register.
module rv_decode_issue
  import rv_decode_issue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Flush,
  input  logic               FetchValid,
  output logic               FetchReady,
  input  logic [31:0]        FetchInstr,
  input  logic [XLEN-1:0]    FetchPC,
  output RegCtrlPortType     DecodeRegReadCtrl1,
  output RegCtrlPortType     DecodeRegReadCtrl2,
  output RegCtrlPortType     DecodeRegWriteCtrl1,
  input  RegReadPortType     DecodeRegReadData1,
  input  RegReadPortType     DecodeRegReadData2,
  output logic               IssueValid,
  input  logic               IssueReady,
  output IssuePacketType     IssuePacket,
  output logic [CNT_W-1:0]   StallCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic            ir_valid_q, ir_valid_d;
  logic [31:0]     ir_instr_q, ir_instr_d;
  logic [XLEN-1:0] ir_pc_q, ir_pc_d;
  logic            iss_valid_q, iss_valid_d;
  IssuePacketType  iss_q, iss_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  OpClassType      dec_op_class;
  RegCtrlPortType  dec_rs1_ctrl;
  RegCtrlPortType  dec_rs2_ctrl;
  RegCtrlPortType  dec_rd_ctrl;
  OperandType      dec_imm;
  logic            dec_illegal;

  logic            ops_ready;
  logic            xfer;
  logic            fetch_accept;

  rv_decode_imm u_decode (
    .instr_i    (ir_instr_q),
    .op_class_o (dec_op_class),
    .rs1_ctrl_o (dec_rs1_ctrl),
    .rs2_ctrl_o (dec_rs2_ctrl),
    .rd_ctrl_o  (dec_rd_ctrl),
    .imm_o      (dec_imm),
    .illegal_o  (dec_illegal)
  );

  // Handshake qualifiers: IR moves to ISS when operands are ready and ISS is
  // free or draining; IR can refill in the same cycle it empties.
  always_comb begin
    ops_ready    = DecodeRegReadData1.isRegAvailable && DecodeRegReadData2.isRegAvailable;
    xfer         = ir_valid_q && ops_ready && (!iss_valid_q || IssueReady) && !Flush;
    FetchReady   = (!ir_valid_q || xfer) && !Flush;
    fetch_accept = FetchValid && FetchReady;
  end

  // Next-state for IR, ISS and the stall counter; flush overrides loads.
  always_comb begin
    ir_valid_d  = ir_valid_q;
    ir_instr_d  = ir_instr_q;
    ir_pc_d     = ir_pc_q;
    iss_valid_d = iss_valid_q;
    iss_d       = iss_q;
    stall_d     = stall_q;

    if (Flush) begin
      ir_valid_d = 1'b0;
    end else if (fetch_accept) begin
      ir_valid_d = 1'b1;
      ir_instr_d = FetchInstr;
      ir_pc_d    = FetchPC;
    end else if (xfer) begin
      ir_valid_d = 1'b0;
    end

    if (Flush) begin
      iss_valid_d = 1'b0;
    end else if (xfer) begin
      iss_valid_d    = 1'b1;
      iss_d.PC       = ir_pc_q;
      iss_d.OpClass  = dec_op_class;
      iss_d.Funct3   = ir_instr_q[14:12];
      iss_d.Funct7b5 = ir_instr_q[30];
      iss_d.Src1Data = DecodeRegReadData1.PhyRegReadData;
      iss_d.Src2Data = DecodeRegReadData2.PhyRegReadData;
      iss_d.Imm      = dec_imm;
      iss_d.RdCtrl   = dec_rd_ctrl;
      iss_d.Illegal  = dec_illegal;
    end else if (iss_valid_q && IssueReady) begin
      iss_valid_d = 1'b0;
    end

    if (ir_valid_q && !xfer && !Flush && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_valid_q  <= 1'b0;
      ir_instr_q  <= '0;
      ir_pc_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
      stall_q     <= '0;
    end else begin
      ir_valid_q  <= ir_valid_d;
      ir_instr_q  <= ir_instr_d;
      ir_pc_q     <= ir_pc_d;
      iss_valid_q <= iss_valid_d;
      iss_q       <= iss_d;
      stall_q     <= stall_d;
    end
  end

  // Register-file control ports: reads follow IR, the write port follows ISS.
  always_comb begin
    DecodeRegReadCtrl1  = ir_valid_q  ? dec_rs1_ctrl : '0;
    DecodeRegReadCtrl2  = ir_valid_q  ? dec_rs2_ctrl : '0;
    DecodeRegWriteCtrl1 = iss_valid_q ? iss_q.RdCtrl : '0;
  end

  assign IssueValid  = iss_valid_q;
  assign IssuePacket = iss_q;
  assign StallCount  = stall_q;

endmodule

// File: tb/tb_rv_decode_issue.sv
// Directed bench for rv_decode_issue: reset, single issue, operand stall,
// streaming, back-pressure, illegal decode, flush, saturation, mid-run reset.
module tb_rv_decode_issue;
  import rv_decode_issue_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           Flush;
  logic           FetchValid;
  logic           FetchReady;
  logic [31:0]    FetchInstr;
  logic [31:0]    FetchPC;
  RegCtrlPortType rc1, rc2, wc1;
  RegReadPortType rd1, rd2;
  logic           IssueValid;
  logic           IssueReady;
  IssuePacketType pkt;
  logic [3:0]     StallCount;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]   s_instr [5];
  logic [31:0]   s_imm   [5];
  OpClassType    s_oc    [5];
  logic          s_rden  [5];

  always #5 clk = ~clk;

  rv_decode_issue #(.XLEN(32), .CNT_W(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .Flush               (Flush),
    .FetchValid          (FetchValid),
    .FetchReady          (FetchReady),
    .FetchInstr          (FetchInstr),
    .FetchPC             (FetchPC),
    .DecodeRegReadCtrl1  (rc1),
    .DecodeRegReadCtrl2  (rc2),
    .DecodeRegWriteCtrl1 (wc1),
    .DecodeRegReadData1  (rd1),
    .DecodeRegReadData2  (rd2),
    .IssueValid          (IssueValid),
    .IssueReady          (IssueReady),
    .IssuePacket         (pkt),
    .StallCount          (StallCount)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    FetchValid = 1'b1;
    FetchInstr = instr;
    FetchPC    = pc;
  endtask

  initial begin
    s_instr[0] = 32'h123452B7; s_imm[0] = 32'h12345000; s_oc[0] = OC_LUI;    s_rden[0] = 1'b1;
    s_instr[1] = 32'h00001317; s_imm[1] = 32'h00001000; s_oc[1] = OC_AUIPC;  s_rden[1] = 1'b1;
    s_instr[2] = 32'h008000EF; s_imm[2] = 32'h00000008; s_oc[2] = OC_JAL;    s_rden[2] = 1'b1;
    s_instr[3] = 32'h0020A623; s_imm[3] = 32'h0000000C; s_oc[3] = OC_STORE;  s_rden[3] = 1'b0;
    s_instr[4] = 32'hFE000EE3; s_imm[4] = 32'hFFFFFFFC; s_oc[4] = OC_BRANCH; s_rden[4] = 1'b0;

    rst_n = 1'b0; Flush = 1'b0; FetchValid = 1'b0; FetchInstr = '0; FetchPC = '0;
    IssueReady = 1'b1;
    rd1.PhyRegReadData = 32'hAAAA0001; rd1.isRegAvailable = 1'b1;
    rd2.PhyRegReadData = 32'hBBBB0002; rd2.isRegAvailable = 1'b1;

    // Reset and idle
    repeat (3) @(negedge clk);
    #1;
    chk("rst_iss_valid", 64'(IssueValid), 64'h0);
    chk("rst_stall", 64'(StallCount), 64'h0);
    chk("rst_fetch_ready", 64'(FetchReady), 64'h1);
    chk("rst_rc1", 64'(rc1), 64'h0);
    chk("rst_rc2", 64'(rc2), 64'h0);
    chk("rst_pkt_imm", 64'(pkt.Imm), 64'h0);
    rst_n = 1'b1;

    // addi x1,x0,5
    @(negedge clk); offer(32'h00500093, 32'h100); #1;
    chk("addi_fetch_ready", 64'(FetchReady), 64'h1);
    @(negedge clk); FetchValid = 1'b0; #1;
    chk("addi_not_yet", 64'(IssueValid), 64'h0);
    chk("addi_rc1", 64'(rc1), 64'h20);
    chk("addi_rc2", 64'(rc2), 64'h0);
    @(negedge clk); offer(32'h002081B3, 32'h104); #1;
    chk("addi_valid", 64'(IssueValid), 64'h1);
    chk("addi_pc", 64'(pkt.PC), 64'h100);
    chk("addi_oc", 64'(pkt.OpClass), 64'(OC_OPIMM));
    chk("addi_imm", 64'(pkt.Imm), 64'h5);
    chk("addi_rdctrl", 64'(pkt.RdCtrl), 64'h21);
    chk("addi_src1", 64'(pkt.Src1Data), 64'hAAAA0001);
    chk("addi_src2", 64'(pkt.Src2Data), 64'hBBBB0002);
    chk("addi_wc1", 64'(wc1), 64'h21);
    chk("addi_illegal", 64'(pkt.Illegal), 64'h0);

    // add x3,x1,x2 with rs1 unavailable for three cycles
    @(negedge clk); FetchValid = 1'b0; rd1.isRegAvailable = 1'b0; #1;
    chk("add_iss_drained", 64'(IssueValid), 64'h0);
    chk("add_fetch_blocked", 64'(FetchReady), 64'h0);
    chk("add_rc1", 64'(rc1), 64'h21);
    chk("add_rc2", 64'(rc2), 64'h22);
    chk("add_stall0", 64'(StallCount), 64'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("add_stall3", 64'(StallCount), 64'h3);
    chk("add_no_issue", 64'(IssueValid), 64'h0);
    rd1.isRegAvailable = 1'b1;
    rd1.PhyRegReadData = 32'h11111111;
    rd2.PhyRegReadData = 32'h22222222;
    #1;
    chk("add_release_ready", 64'(FetchReady), 64'h1);
    @(negedge clk); #1;
    chk("add_valid", 64'(IssueValid), 64'h1);
    chk("add_oc", 64'(pkt.OpClass), 64'(OC_OP));
    chk("add_src1", 64'(pkt.Src1Data), 64'h11111111);
    chk("add_src2", 64'(pkt.Src2Data), 64'h22222222);
    chk("add_imm", 64'(pkt.Imm), 64'h0);
    chk("add_rdctrl", 64'(pkt.RdCtrl), 64'h23);
    chk("add_stall_held", 64'(StallCount), 64'h3);

    // Back-to-back stream, one issue per cycle
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j < 5) offer(s_instr[j], 32'h200 + 32'(4 * j));
      else FetchValid = 1'b0;
      #1;
      if (j < 5) chk("stream_ready", 64'(FetchReady), 64'h1);
      if (j == 1) begin
        chk("lui_rc1", 64'(rc1), 64'h0);
        chk("lui_rc2", 64'(rc2), 64'h0);
        chk("stream_gap", 64'(IssueValid), 64'h0);
      end
      if (j >= 2) begin
        chk("stream_valid", 64'(IssueValid), 64'h1);
        chk("stream_pc", 64'(pkt.PC), 64'(32'h200 + 32'(4 * (j - 2))));
        chk("stream_imm", 64'(pkt.Imm), 64'(s_imm[j - 2]));
        chk("stream_oc", 64'(pkt.OpClass), 64'(s_oc[j - 2]));
        chk("stream_rden", 64'(pkt.RdCtrl.RegEnable), 64'(s_rden[j - 2]));
      end
    end

    // Back-pressure with IR and ISS both full
    @(negedge clk); IssueReady = 1'b0; offer(32'hFFF00393, 32'h300); #1;
    chk("bp_start_empty", 64'(IssueValid), 64'h0);
    chk("bp_accept_a", 64'(FetchReady), 64'h1);
    @(negedge clk); offer(32'h7FF00413, 32'h304); #1;
    chk("bp_accept_b", 64'(FetchReady), 64'h1);
    @(negedge clk); offer(32'h00100493, 32'h308); #1;
    chk("bp_block_c", 64'(FetchReady), 64'h0);
    chk("bp_valid", 64'(IssueValid), 64'h1);
    chk("bp_pc", 64'(pkt.PC), 64'h300);
    chk("bp_stall", 64'(StallCount), 64'h3);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      chk("bp_hold_pc", 64'(pkt.PC), 64'h300);
      chk("bp_hold_imm", 64'(pkt.Imm), 64'hFFFFFFFF);
      chk("bp_hold_valid", 64'(IssueValid), 64'h1);
      chk("bp_hold_ready", 64'(FetchReady), 64'h0);
    end
    @(negedge clk); #1;
    chk("bp_stall7", 64'(StallCount), 64'h7);
    chk("bp_still_a", 64'(pkt.PC), 64'h300);
    IssueReady = 1'b1; #1;
    chk("bp_release_ready", 64'(FetchReady), 64'h1);
    @(negedge clk); FetchValid = 1'b0; #1;
    chk("bp_b_pc", 64'(pkt.PC), 64'h304);
    chk("bp_b_imm", 64'(pkt.Imm), 64'h7FF);
    @(negedge clk); #1;
    chk("bp_c_pc", 64'(pkt.PC), 64'h308);
    chk("bp_c_imm", 64'(pkt.Imm), 64'h1);

    // Illegal instruction word 0
    @(negedge clk); offer(32'h00000000, 32'h400); #1;
    chk("ill_drained", 64'(IssueValid), 64'h0);
    chk("ill_stall", 64'(StallCount), 64'h7);
    @(negedge clk); FetchValid = 1'b0; #1;
    chk("ill_rc1", 64'(rc1), 64'h0);
    chk("ill_rc2", 64'(rc2), 64'h0);
    @(negedge clk); IssueReady = 1'b0; offer(32'h00500093, 32'h404); #1;
    chk("ill_valid", 64'(IssueValid), 64'h1);
    chk("ill_flag", 64'(pkt.Illegal), 64'h1);
    chk("ill_oc", 64'(pkt.OpClass), 64'(OC_ILLEGAL));
    chk("ill_rden", 64'(pkt.RdCtrl.RegEnable), 64'h0);
    chk("ill_imm", 64'(pkt.Imm), 64'h0);
    chk("ill_wc1", 64'(wc1), 64'h0);

    // Flush with IR and ISS full
    @(negedge clk); Flush = 1'b1; offer(32'h00200113, 32'h408); #1;
    chk("flush_ready", 64'(FetchReady), 64'h0);
    chk("flush_pre_valid", 64'(IssueValid), 64'h1);
    chk("flush_pre_rc1", 64'(rc1), 64'h20);
    @(negedge clk); Flush = 1'b0; FetchValid = 1'b0; IssueReady = 1'b1; #1;
    chk("flush_iss_empty", 64'(IssueValid), 64'h0);
    chk("flush_ir_empty", 64'(rc1), 64'h0);
    chk("flush_ready_after", 64'(FetchReady), 64'h1);
    chk("flush_stall", 64'(StallCount), 64'h7);
    chk("flush_wc1", 64'(wc1), 64'h0);
    @(negedge clk); #1;
    chk("flush_no_issue1", 64'(IssueValid), 64'h0);
    @(negedge clk); #1;
    chk("flush_no_issue2", 64'(IssueValid), 64'h0);

    // Stall counter saturation
    @(negedge clk); rd1.isRegAvailable = 1'b0; offer(32'h00500093, 32'h500); #1;
    @(negedge clk); FetchValid = 1'b0; #1;
    repeat (10) @(negedge clk);
    #1;
    chk("sat_stall", 64'(StallCount), 64'hF);
    rd1.isRegAvailable = 1'b1;
    @(negedge clk); #1;
    chk("sat_issue", 64'(IssueValid), 64'h1);
    chk("sat_pc", 64'(pkt.PC), 64'h500);
    chk("sat_stall_held", 64'(StallCount), 64'hF);

    // Reset mid-operation with IR and ISS full
    IssueReady = 1'b0; offer(32'h00700393, 32'h504);
    @(negedge clk); FetchValid = 1'b0; #1;
    chk("mrst_pre_valid", 64'(IssueValid), 64'h1);
    chk("mrst_pre_rc1", 64'(rc1), 64'h20);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("mrst_valid", 64'(IssueValid), 64'h0);
    chk("mrst_stall", 64'(StallCount), 64'h0);
    chk("mrst_pkt_pc", 64'(pkt.PC), 64'h0);
    chk("mrst_pkt_imm", 64'(pkt.Imm), 64'h0);
    chk("mrst_rc1", 64'(rc1), 64'h0);
    @(negedge clk); IssueReady = 1'b1; #1;
    @(negedge clk); #1;
    chk("mrst_no_issue", 64'(IssueValid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
